// File: rtl/key_event_ctrl_pkg.sv
// rtl/key_event_ctrl_pkg.sv - register map, control fields and address decode for key_event_ctrl
package key_event_ctrl_pkg;

  localparam logic [31:0] KEY_STATE_ADDR = 32'h0000_7F40;
  localparam logic [31:0] KEY_EVT_ADDR   = 32'h0000_7F44;
  localparam logic [31:0] KEY_MASK_ADDR  = 32'h0000_7F48;
  localparam logic [31:0] KEY_CTRL_ADDR  = 32'h0000_7F4C;
  localparam logic [31:0] KEY_REL_ADDR   = 32'h0000_7F50;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STATE,
    REG_EVT,
    REG_MASK,
    REG_CTRL,
    REG_REL
  } reg_sel_e;

  function automatic reg_sel_e reg_decode(input logic [31:0] addr);
    case (addr)
      KEY_STATE_ADDR: return REG_STATE;
      KEY_EVT_ADDR:   return REG_EVT;
      KEY_MASK_ADDR:  return REG_MASK;
      KEY_CTRL_ADDR:  return REG_CTRL;
      KEY_REL_ADDR:   return REG_REL;
      default:        return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - single-key tick-sampled debouncer with press/release pulses
module key_debounce #(
  parameter int DEB_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sample,
  output logic state,
  output logic press,
  output logic rel
);

  logic [DEB_LEN-1:0] hist;
  logic [DEB_LEN-1:0] hist_next;

  assign hist_next = {hist[DEB_LEN-2:0], sample};

  // State is judged on the history including this tick's sample, so nothing moves between ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist  <= '0;
      state <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (tick) begin
        hist <= hist_next;
        if ((&hist_next) && !state) begin
          state <= 1'b1;
          press <= 1'b1;
        end else if (!(|hist_next) && state) begin
          state <= 1'b0;
          rel   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - 8-key debounce/event controller with maskable irq; KEY_RELEASE_EVT_EN adds KEY_REL
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int DEB_LEN        = 4,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [7:0]  key_raw,
  output logic [31:0] rdata,
  output logic        key_irq
);

  localparam int             CNT_W      = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]     IDLE_LEVEL = (KEY_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [7:0]       sync_meta, sync_out, key_sync;
  logic [CNT_W-1:0] presc;
  logic             tick, en;
  logic [7:0]       key_state, press, rel_pulse;
  logic [7:0]       evt, mask, evt_clr, irq_src;
  reg_sel_e         sel;
  logic             wr_evt, wr_mask, wr_ctrl, clr_all;

  // Synchroniser resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= IDLE_LEVEL;
      sync_out  <= IDLE_LEVEL;
    end else begin
      sync_meta <= key_raw;
      sync_out  <= sync_meta;
    end
  end

  assign key_sync = (KEY_ACTIVE_LOW != 0) ? ~sync_out : sync_out;

  assign tick = en && (presc == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_key
    key_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .sample (key_sync[i]),
      .state  (key_state[i]),
      .press  (press[i]),
      .rel    (rel_pulse[i])
    );
  end

  assign sel     = reg_decode(addr);
  assign wr_evt  = we && (sel == REG_EVT);
  assign wr_mask = we && (sel == REG_MASK);
  assign wr_ctrl = we && (sel == REG_CTRL);
  assign clr_all = wr_ctrl && wdata[CTRL_CLR_BIT];
  assign evt_clr = clr_all ? 8'hFF : (wr_evt ? wdata[7:0] : 8'h00);

`ifdef KEY_RELEASE_EVT_EN
  logic [7:0] rel_flags, rel_clr;
  logic       unused_bits;

  assign rel_clr     = clr_all ? 8'hFF : ((we && (sel == REG_REL)) ? wdata[7:0] : 8'h00);
  assign irq_src     = evt | rel_flags;
  assign unused_bits = ^wdata[31:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      rel_flags <= '0;
    end else begin
      rel_flags <= (rel_flags & ~rel_clr) | rel_pulse;
    end
  end
`else
  logic unused_bits;

  assign irq_src     = evt;
  assign unused_bits = ^{wdata[31:8], rel_pulse};
`endif

  // Set is OR-ed in after the clear so a same-cycle press survives the W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt     <= '0;
      mask    <= '0;
      en      <= CTRL_RESET[CTRL_EN_BIT];
      key_irq <= 1'b0;
    end else begin
      evt     <= (evt & ~evt_clr) | press;
      key_irq <= |(irq_src & mask);
      if (wr_mask) mask <= wdata[7:0];
      if (wr_ctrl) en <= wdata[CTRL_EN_BIT];
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_STATE: rdata = {24'b0, key_state};
      REG_EVT:   rdata = {24'b0, evt};
      REG_MASK:  rdata = {24'b0, mask};
      REG_CTRL:  rdata[CTRL_EN_BIT] = en;
`ifdef KEY_RELEASE_EVT_EN
      REG_REL:   rdata = {24'b0, rel_flags};
`endif
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - directed self-checking bench for key_event_ctrl (TICK_DIV=4, DEB_LEN=4)
module tb_key_event_ctrl;
  import key_event_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [7:0]  key_raw;
  logic [31:0] rdata;
  logic        key_irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  key_event_ctrl #(.TICK_DIV(4), .DEB_LEN(4), .KEY_ACTIVE_LOW(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .key_raw (key_raw),
    .rdata   (rdata),
    .key_irq (key_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    #1;
    check(name, {31'b0, key_irq}, {31'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int found;

    vecs[0]  = '{1'b0, KEY_STATE_ADDR, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, KEY_EVT_ADDR,   32'h0,         32'h0};
    vecs[2]  = '{1'b0, KEY_MASK_ADDR,  32'h0,         32'h0};
    vecs[3]  = '{1'b0, KEY_CTRL_ADDR,  32'h0,         32'h1};
    vecs[4]  = '{1'b0, KEY_REL_ADDR,   32'h0,         32'h0};
    vecs[5]  = '{1'b0, 32'h0000_7F3C,  32'h0,         32'h0};
    vecs[6]  = '{1'b1, KEY_MASK_ADDR,  32'hFFFF_FFA5, 32'hA5};
    vecs[7]  = '{1'b1, KEY_STATE_ADDR, 32'hFF,        32'h0};
    vecs[8]  = '{1'b1, 32'h0000_7F54,  32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b1, KEY_CTRL_ADDR,  32'h3,         32'h1};
    vecs[10] = '{1'b1, KEY_EVT_ADDR,   32'hFF,        32'h0};
    vecs[11] = '{1'b1, KEY_MASK_ADDR,  32'h0,         32'h0};

    reset   = 1'b1;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    key_raw = 8'hFF;
    step(3);
    reset = 1'b0;

    chk_irq("reset_irq", 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      step(1);
    end

    // Partial press interrupted by reset: history must restart from empty.
    key_raw[3] = 1'b0;
    step(14);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(8);
    key_raw[3] = 1'b1;
    step(30);
    rd("midreset_state", KEY_STATE_ADDR, 32'h0);
    rd("midreset_evt", KEY_EVT_ADDR, 32'h0);

    key_raw[2] = 1'b0;
    step(26);
    rd("press_state", KEY_STATE_ADDR, 32'h04);
    rd("press_evt", KEY_EVT_ADDR, 32'h04);
    chk_irq("press_irq_masked", 1'b0);
    wr(KEY_MASK_ADDR, 32'h04);
    chk_irq("mask_irq_lag", 1'b0);
    step(1);
    chk_irq("mask_irq", 1'b1);

    for (int i = 0; i < 10; i++) begin
      key_raw[5] = ~key_raw[5];
      step(4);
    end
    step(8);
    rd("bounce_state", KEY_STATE_ADDR, 32'h04);
    rd("bounce_evt", KEY_EVT_ADDR, 32'h04);

    key_raw[6] = 1'b0;
    step(8);
    key_raw[6] = 1'b1;
    step(20);
    rd("short_state", KEY_STATE_ADDR, 32'h04);
    rd("short_evt", KEY_EVT_ADDR, 32'h04);

    wr(KEY_EVT_ADDR, 32'h04);
    rd("w1c_evt", KEY_EVT_ADDR, 32'h0);
    chk_irq("w1c_irq_lag", 1'b1);
    step(1);
    chk_irq("w1c_irq", 1'b0);

    key_raw[2] = 1'b1;
    step(26);
    rd("release_state", KEY_STATE_ADDR, 32'h0);
    rd("release_evt", KEY_EVT_ADDR, 32'h0);

    // Land a W1C on the exact cycle the press pulse sets the flag.
    key_raw[2] = 1'b0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      addr = KEY_STATE_ADDR;
      #1;
      if (rdata[2]) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("setwins_seen", 32'(found), 32'd1);
    wr(KEY_EVT_ADDR, 32'h04);
    rd("setwins_evt", KEY_EVT_ADDR, 32'h04);
    step(1);
    chk_irq("setwins_irq", 1'b1);

    key_raw[2] = 1'b1;
    step(26);
    rd("rel2_state", KEY_STATE_ADDR, 32'h0);
    wr(KEY_CTRL_ADDR, 32'h0);
    rd("dis_ctrl", KEY_CTRL_ADDR, 32'h0);
    key_raw[0] = 1'b0;
    step(40);
    rd("dis_state", KEY_STATE_ADDR, 32'h0);
    rd("dis_evt", KEY_EVT_ADDR, 32'h04);
    chk_irq("dis_irq", 1'b1);

    wr(KEY_CTRL_ADDR, 32'h1);
    step(13);
    rd("en3_state", KEY_STATE_ADDR, 32'h0);
    rd("en3_evt", KEY_EVT_ADDR, 32'h04);
    step(6);
    rd("en4_state", KEY_STATE_ADDR, 32'h01);
    rd("en4_evt", KEY_EVT_ADDR, 32'h05);

    wr(KEY_CTRL_ADDR, 32'h3);
    rd("clrall_evt", KEY_EVT_ADDR, 32'h0);
    rd("clrall_ctrl", KEY_CTRL_ADDR, 32'h1);
    step(1);
    chk_irq("clrall_irq", 1'b0);
    key_raw[0] = 1'b1;
    step(26);
    rd("rel0_state", KEY_STATE_ADDR, 32'h0);

    key_raw[7] = 1'b0;
    step(26);
    rd("k7_state", KEY_STATE_ADDR, 32'h80);
    wr(KEY_CTRL_ADDR, 32'h3);
    wr(KEY_MASK_ADDR, 32'h80);
    key_raw[7] = 1'b1;
    step(26);
    rd("k7_rel_state", KEY_STATE_ADDR, 32'h0);
    rd("k7_evt", KEY_EVT_ADDR, 32'h0);
`ifdef KEY_RELEASE_EVT_EN
    rd("k7_rel", KEY_REL_ADDR, 32'h80);
    chk_irq("k7_rel_irq", 1'b1);
    wr(KEY_REL_ADDR, 32'h80);
    rd("k7_rel_w1c", KEY_REL_ADDR, 32'h0);
    step(1);
    chk_irq("k7_rel_irq_clr", 1'b0);
`else
    rd("k7_rel", KEY_REL_ADDR, 32'h0);
    chk_irq("k7_rel_irq", 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
